// File: rtl/sipo_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sipo_pkg
// Purpose  : Shared defaults, flush-state encoding and width helper for the
//            sipo_packer pixel-stream packer.
// Revision : 1.0  initial release
// ============================================================================
package sipo_pkg;

   localparam int IN_W_DEF  = 10;
   localparam int OUT_W_DEF = 256;

   // Flush handshake state: IDLE accepts data, PEND drains the partial word
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      PEND = 1'b1
   } flush_state_t;

   // Width of the fill counter that indexes bit positions inside one word
   function automatic int cnt_w(input int out_w);
      return $clog2(out_w);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : sipo_out_reg
// Purpose  : Output holding register with valid/ready. A load strobe always
//            wins, so a new word may replace one leaving in the same cycle.
//            With SIPO_PACKER_FILL_EN defined it also carries the fill count.
// Revision : 1.0  initial release
// ============================================================================
module sipo_out_reg
   import sipo_pkg::*;
#(
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          load,
   input  logic [OUT_W-1:0]              load_data,
`ifdef SIPO_PACKER_FILL_EN
   input  logic [$clog2(OUT_W+1)-1:0]    load_fill,
   output logic [$clog2(OUT_W+1)-1:0]    out_fill,
`endif
   input  logic                          out_ready,
   output logic                          out_valid,
   output logic [OUT_W-1:0]              out_data
);

   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_data_q,  out_data_d;
`ifdef SIPO_PACKER_FILL_EN
   logic [$clog2(OUT_W+1)-1:0] out_fill_q, out_fill_d;
`endif

   // Load a new word, otherwise drop valid once the held word is taken
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
`ifdef SIPO_PACKER_FILL_EN
      out_fill_d  = out_fill_q;
`endif
      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = load_data;
`ifdef SIPO_PACKER_FILL_EN
         out_fill_d  = load_fill;
`endif
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Holding register; reset discards any word still waiting
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
`ifdef SIPO_PACKER_FILL_EN
         out_fill_q  <= '0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
`ifdef SIPO_PACKER_FILL_EN
         out_fill_q  <= out_fill_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
`ifdef SIPO_PACKER_FILL_EN
   assign out_fill  = out_fill_q;
`endif

endmodule
`default_nettype wire

// File: rtl/sipo_packer.sv
`default_nettype none
// ============================================================================
// Module   : sipo_packer
// Purpose  : Packs IN_W-bit pixel samples bit-contiguously into OUT_W-bit
//            words (earliest sample in the LSBs) with valid/ready on both
//            sides and a flush that emits a zero-padded partial word.
//            Optional macro SIPO_PACKER_FILL_EN adds the out_fill port.
// Revision : 1.0  initial release
// ============================================================================
module sipo_packer
   import sipo_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [IN_W-1:0]               in_data,
   input  logic                          flush,
   output logic                          flush_done,
   output logic                          out_valid,
   input  logic                          out_ready,
`ifdef SIPO_PACKER_FILL_EN
   output logic [$clog2(OUT_W+1)-1:0]    out_fill,
`endif
   output logic [OUT_W-1:0]              out_data
);

   // Guard against a zero-width counter for the degenerate OUT_W == 1 case
   localparam int CNT_W = (cnt_w(OUT_W) > 0) ? cnt_w(OUT_W) : 1;
   // cnt + IN_W never reaches 2*OUT_W, so one extra bit is enough
   localparam int SUM_W = CNT_W + 1;
   localparam int ACC_W = OUT_W + IN_W - 1;
   localparam logic [SUM_W-1:0] OUT_W_S = SUM_W'(OUT_W);
   localparam logic [SUM_W-1:0] IN_W_S  = SUM_W'(IN_W);
`ifdef SIPO_PACKER_FILL_EN
   localparam int FILL_W = $clog2(OUT_W+1);
`endif

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   flush_state_t     flush_q, flush_d;
   logic             flush_done_q, flush_done_d;

   logic             out_free;
   logic             in_xfer;
   logic [SUM_W-1:0] fill_sum;
   logic             fits;
   logic [ACC_W-1:0] acc_ins;
   logic [OUT_W-1:0] low_mask;
   logic             load;
   logic [OUT_W-1:0] load_data;
`ifdef SIPO_PACKER_FILL_EN
   logic [FILL_W-1:0] load_fill;
`endif

   // out_free depends combinationally on out_ready so a full word can be
   // replaced in the very cycle the previous one leaves
   assign out_free = !out_valid || out_ready;
   assign fill_sum = {1'b0, cnt_q} + IN_W_S;
   assign fits     = fill_sum < OUT_W_S;
   assign in_ready = (flush_q == IDLE) && (fits || out_free);
   assign in_xfer  = in_valid && in_ready;
   // Bits at and above cnt are always zero, so OR-ing places the sample
   assign acc_ins  = acc_q | (ACC_W'(in_data) << cnt_q);
   assign low_mask = ~({OUT_W{1'b1}} << cnt_q);

   // Next-state: accumulate samples, emit full words, drain on flush
   always_comb begin
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      flush_d      = flush_q;
      flush_done_d = 1'b0;
      load         = 1'b0;
      load_data    = acc_ins[OUT_W-1:0];
`ifdef SIPO_PACKER_FILL_EN
      load_fill    = FILL_W'(OUT_W);
`endif
      case (flush_q)
         IDLE: begin
            if (flush) begin
               flush_d = PEND;
            end
            if (in_xfer) begin
               if (fits) begin
                  acc_d = acc_ins;
                  cnt_d = fill_sum[CNT_W-1:0];
               end else begin
                  // Word complete: leftover high bits drop to the bottom
                  load  = 1'b1;
                  acc_d = acc_ins >> OUT_W;
                  cnt_d = CNT_W'(fill_sum - OUT_W_S);
               end
            end
         end
         PEND: begin
            if (cnt_q == '0) begin
               flush_d      = IDLE;
               flush_done_d = 1'b1;
            end else if (out_free) begin
               load         = 1'b1;
               load_data    = acc_q[OUT_W-1:0] & low_mask;
`ifdef SIPO_PACKER_FILL_EN
               load_fill    = FILL_W'(cnt_q);
`endif
               cnt_d        = '0;
               acc_d        = '0;
               flush_d      = IDLE;
               flush_done_d = 1'b1;
            end
         end
         default: flush_d = IDLE;
      endcase
   end

   // Packer state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         acc_q        <= '0;
         flush_q      <= IDLE;
         flush_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         flush_q      <= flush_d;
         flush_done_q <= flush_done_d;
      end
   end

   assign flush_done = flush_done_q;

   sipo_out_reg #(
      .OUT_W     (OUT_W)
   ) u_out_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_data (load_data),
`ifdef SIPO_PACKER_FILL_EN
      .load_fill (load_fill),
      .out_fill  (out_fill),
`endif
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data)
   );

endmodule
`default_nettype wire

// File: tb/tb_sipo_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_packer
// Purpose  : Directed self-checking bench for sipo_packer (IN_W=10,
//            OUT_W=256, sample k carries value k).
// Revision : 1.0  initial release
// ============================================================================
module tb_sipo_packer;

   localparam int IN_W  = 10;
   localparam int OUT_W = 256;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [IN_W-1:0]   in_data;
   logic              flush;
   logic              flush_done;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  out_data;
`ifdef SIPO_PACKER_FILL_EN
   logic [8:0]        out_fill;
`endif

   int n_checks = 0;
   int n_errs   = 0;
   int stalls   = 0;
   logic [OUT_W-1:0] words[$];
   logic [1279:0]    big;
   logic [OUT_W-1:0] exp1;

   sipo_packer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .flush      (flush),
      .flush_done (flush_done),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
`ifdef SIPO_PACKER_FILL_EN
      .out_fill   (out_fill),
`endif
      .out_data   (out_data)
   );

   always #5 clk = ~clk;

   // Record accepted output words and input stalls midway between edges
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) words.push_back(out_data);
      if (!rst && in_valid && !in_ready) stalls++;
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   // Present sample k until it is accepted; returns 1 time unit after that edge
   task automatic beat(input int k);
      logic [31:0] kv;
      kv = k;
      in_valid = 1'b1;
      in_data  = kv[IN_W-1:0];
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
      check("beat_timeout", 0, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 128; k++) big[10*k +: 10] = 10'(k);
      exp1 = big[255:0];
      out_ready = 1'b1;

      // ---- Reset state, then 26 beats ----
      do_reset();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_flush_done", flush_done, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_cnt", dut.cnt_q, 0);
      words.delete();
      for (int k = 0; k < 25; k++) beat(k);
      check("s1_no_word_yet", out_valid, 0);
      beat(25);
      check("s1_valid", out_valid, 1);
      check("s1_word", out_data, exp1);
      check("s1_cnt", dut.cnt_q, 4);
`ifdef SIPO_PACKER_FILL_EN
      check("s1_fill", out_fill, 256);
`endif
      step();
      check("s1_taken", out_valid, 0);
      check("s1_nwords", words.size(), 1);

      // ---- 128 continuous beats ----
      do_reset();
      words.delete();
      stalls = 0;
      for (int k = 0; k < 128; k++) beat(k);
      step();
      check("s2_nwords", words.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < words.size()) check($sformatf("s2_word%0d", i), words[i], big[256*i +: 256]);
      check("s2_cnt", dut.cnt_q, 0);
      check("s2_stalls", stalls, 0);

      // ---- Backpressure: out_ready low from reset ----
      out_ready = 1'b0;
      do_reset();
      words.delete();
      for (int k = 0; k < 26; k++) beat(k);
      check("s3_held_valid", out_valid, 1);
      check("s3_held_word", out_data, exp1);
      for (int k = 26; k < 50; k++) beat(k);
      check("s3_ready_before", in_ready, 1);
      beat(50);
      check("s3_cnt_full", dut.cnt_q, 254);
      check("s3_ready_drop", in_ready, 0);
      step();
      check("s3_still_held", out_data, exp1);
      check("s3_still_valid", out_valid, 1);
      check("s3_no_out", words.size(), 0);
      out_ready = 1'b1;
      beat(51);
      check("s3_replace_valid", out_valid, 1);
      step();
      step();
      check("s3_nwords", words.size(), 2);
      if (words.size() == 2) begin
         check("s3_word0", words[0], big[255:0]);
         check("s3_word1", words[1], big[511:256]);
      end
      check("s3_cnt_end", dut.cnt_q, 8);

      // ---- 3 beats, flush coinciding with the last beat ----
      do_reset();
      words.delete();
      beat(0);
      beat(1);
      flush = 1'b1;
      beat(2);
      flush = 1'b0;
      check("s4_pend_ready", in_ready, 0);
      check("s4_pend_valid", out_valid, 0);
      check("s4_pend_done", flush_done, 0);
      step();
      check("s4_valid", out_valid, 1);
      check("s4_done", flush_done, 1);
      check("s4_word", out_data, 256'h200400);
`ifdef SIPO_PACKER_FILL_EN
      check("s4_fill", out_fill, 30);
`endif
      step();
      check("s4_done_pulse", flush_done, 0);
      check("s4_ready_back", in_ready, 1);
      check("s4_nwords", words.size(), 1);

      // ---- Flush with an empty accumulator ----
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("s5_pend_ready", in_ready, 0);
      check("s5_pend_done", flush_done, 0);
      step();
      check("s5_done", flush_done, 1);
      check("s5_no_word", out_valid, 0);
      check("s5_ready_back", in_ready, 1);
      step();
      check("s5_done_pulse", flush_done, 0);
      check("s5_nwords", words.size(), 1);

      // ---- Reset mid-word with a held output word ----
      out_ready = 1'b0;
      do_reset();
      for (int k = 0; k < 39; k++) beat(k);
      check("s6_held", out_valid, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("s6_rst_valid", out_valid, 0);
      check("s6_rst_cnt", dut.cnt_q, 0);
      check("s6_rst_data", out_data, 0);
      out_ready = 1'b1;
      words.delete();
      for (int k = 0; k < 26; k++) beat(k);
      check("s6_word", out_data, exp1);
      check("s6_cnt", dut.cnt_q, 4);
      step();
      check("s6_nwords", words.size(), 1);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
